// File: rtl/cpu5_lsu.sv
// Load/store unit: one req/gnt/rvalid bus transaction per core memory op,
// with byte/half/word lane steering, load extension, misalign and timeout detection.
module cpu5_lsu #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            lsu_req,
  input  logic            lsu_we,
  input  logic [1:0]      lsu_size,
  input  logic            lsu_unsigned,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_stall,
  output logic            lsu_misalign,
  output logic            lsu_err,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_be,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_t          r_state;
  logic [7:0]      r_cnt;
  logic [1:0]      r_off;
  logic [1:0]      r_size;
  logic            r_uns;
  logic            r_bus_req;
  logic            r_bus_we;
  logic [XLEN-1:0] r_bus_addr;
  logic [XLEN-1:0] r_bus_wdata;
  logic [3:0]      r_bus_be;
  logic [XLEN-1:0] r_rdata;
  logic            r_err;

  logic            w_misaligned;
  logic            w_tmo;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_ext;

  assign w_misaligned = ((lsu_size == 2'b01) & lsu_addr[0]) |
                        (lsu_size[1] & (lsu_addr[1:0] != 2'b00));
  assign lsu_misalign = (r_state == S_IDLE) & lsu_req & w_misaligned;
  assign lsu_stall    = lsu_req & (r_state != S_DONE) & ~lsu_misalign;
  // >= rather than == so a grant on the last allowed cycle still bounds the WAIT phase
  assign w_tmo        = (r_cnt >= CntLast);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = lsu_wdata;
    case (lsu_size)
      2'b00: begin
        w_be    = 4'b0001 << lsu_addr[1:0];
        w_wdata = {4{lsu_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = lsu_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{lsu_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = bus_rdata[7:0];
    case (r_off)
      2'd1:    w_byte = bus_rdata[15:8];
      2'd2:    w_byte = bus_rdata[23:16];
      2'd3:    w_byte = bus_rdata[XLEN-1:24];
      default: w_byte = bus_rdata[7:0];
    endcase
    w_half = r_off[1] ? bus_rdata[XLEN-1:16] : bus_rdata[15:0];
    case (r_size)
      2'b00:   w_ext = {{(XLEN-8){~r_uns & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{(XLEN-16){~r_uns & w_half[15]}}, w_half};
      default: w_ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_off       <= '0;
      r_size      <= '0;
      r_uns       <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_be    <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (lsu_req && !w_misaligned) begin
            r_bus_addr  <= {lsu_addr[XLEN-1:2], 2'b00};
            r_bus_we    <= lsu_we;
            r_bus_be    <= w_be;
            r_bus_wdata <= w_wdata;
            r_off       <= lsu_addr[1:0];
            r_size      <= lsu_size;
            r_uns       <= lsu_unsigned;
            r_cnt       <= '0;
            r_bus_req   <= 1'b1;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus_gnt) begin
            r_bus_req <= 1'b0;
            r_cnt     <= r_cnt + 8'd1;
            r_state   <= S_WAIT;
          end else if (w_tmo) begin
            r_bus_req <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WAIT: begin
          if (bus_rvalid) begin
            r_err   <= bus_err;
            r_state <= S_DONE;
            if (!r_bus_we && !bus_err) r_rdata <= w_ext;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_be    = r_bus_be;
  assign lsu_rdata = r_rdata;
  assign lsu_err   = r_err;

endmodule

// File: tb/tb_cpu5_lsu.sv
// Self-checking bench for cpu5_lsu: directed cases plus randomized ops
// against a lane/extension model built from byte counts and offsets.
module tb_cpu5_lsu;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        lsu_req, lsu_we, lsu_unsigned;
  logic [1:0]  lsu_size;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        lsu_stall, lsu_misalign, lsu_err;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] m_rdata = '0;

  cpu5_lsu #(.XLEN(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_size(lsu_size), .lsu_unsigned(lsu_unsigned),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_rdata(lsu_rdata),
    .lsu_stall(lsu_stall), .lsu_misalign(lsu_misalign), .lsu_err(lsu_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit m_mis(input logic [1:0] sz, input logic [31:0] a);
    return (int'(a[1:0]) % nbytes(sz)) != 0;
  endfunction

  function automatic int m_base(input logic [1:0] sz, input logic [31:0] a);
    return int'(a[1:0]) - (int'(a[1:0]) % nbytes(sz));
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] be = '0;
    for (int k = 0; k < nbytes(sz); k++) be[m_base(sz, a) + k] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = d[8*(k % nbytes(sz)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] a,
                                         input logic uns, input logic [31:0] r);
    logic [31:0] v = '0;
    int n = nbytes(sz);
    for (int k = 0; k < n; k++) v[8*k +: 8] = r[8*(m_base(sz, a) + k) +: 8];
    if (!uns && n < 4 && v[8*n-1])
      for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  // Issue one op; gd/rd are idle cycles before gnt/rvalid. Returns one cycle after DONE.
  task automatic do_op(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d, input int gd, input int rd,
                       input logic [31:0] rdat, input logic berr, input logic stray);
    lsu_req = 1'b1; lsu_we = we; lsu_size = sz; lsu_unsigned = uns;
    lsu_addr = a; lsu_wdata = d; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
    @(negedge clk);
    chk("idle_err", {31'd0, lsu_err}, 32'd0);
    chk("idle_busreq", {31'd0, bus_req}, 32'd0);
    if (m_mis(sz, a)) begin
      chk("mis_flag", {31'd0, lsu_misalign}, 32'd1);
      chk("mis_stall", {31'd0, lsu_stall}, 32'd0);
      step();
      return;
    end
    chk("idle_mis", {31'd0, lsu_misalign}, 32'd0);
    chk("idle_stall", {31'd0, lsu_stall}, 32'd1);
    step();
    for (int i = 0; i <= gd; i++) begin
      bus_gnt    = (i == gd);
      bus_rvalid = stray && (i != gd);
      bus_err    = 1'b1;
      bus_rdata  = $urandom;
      @(negedge clk);
      chk("req_busreq", {31'd0, bus_req}, 32'd1);
      chk("req_stall", {31'd0, lsu_stall}, 32'd1);
      chk("req_addr", bus_addr, {a[31:2], 2'b00});
      chk("req_be", {28'd0, bus_be}, {28'd0, m_be(sz, a)});
      chk("req_wdata", bus_wdata, m_wdata(sz, d));
      chk("req_we", {31'd0, bus_we}, {31'd0, we});
      step();
    end
    bus_gnt = 1'b0;
    for (int i = 0; i <= rd; i++) begin
      bus_rvalid = (i == rd);
      bus_rdata  = (i == rd) ? rdat : $urandom;
      bus_err    = (i == rd) ? berr : 1'($urandom);
      @(negedge clk);
      chk("wait_busreq", {31'd0, bus_req}, 32'd0);
      chk("wait_stall", {31'd0, lsu_stall}, 32'd1);
      chk("wait_be", {28'd0, bus_be}, {28'd0, m_be(sz, a)});
      step();
    end
    bus_rvalid = 1'b0; bus_err = 1'b0;
    if (!we && !berr) m_rdata = m_load(sz, a, uns, rdat);
    @(negedge clk);
    chk("done_stall", {31'd0, lsu_stall}, 32'd0);
    chk("done_err", {31'd0, lsu_err}, {31'd0, berr});
    chk("done_rdata", lsu_rdata, m_rdata);
    chk("done_addr", bus_addr, {a[31:2], 2'b00});
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit done;
    lsu_req = 0; lsu_we = 0; lsu_size = 0; lsu_unsigned = 0; lsu_addr = 0; lsu_wdata = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0; bus_err = 0;
    #2 reset = 1'b0;
    #2;
    chk("rst_busreq", {31'd0, bus_req}, 32'd0);
    chk("rst_be", {28'd0, bus_be}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_rdata", lsu_rdata, 32'd0);
    chk("rst_err", {31'd0, lsu_err}, 32'd0);
    step(); step();
    reset = 1'b1;
    step();

    do_op(0, 2'b10, 0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 0, 0);
    do_op(0, 2'b00, 0, 32'h103, 32'h0, 1, 0, 32'h80123456, 0, 0);
    do_op(0, 2'b00, 1, 32'h103, 32'h0, 0, 1, 32'h80123456, 0, 1);
    do_op(0, 2'b01, 1, 32'h102, 32'h0, 0, 0, 32'hBEEF0000, 0, 0);
    do_op(1, 2'b00, 0, 32'h201, 32'h12345678, 0, 0, 32'hFFFFFFFF, 0, 0);
    do_op(1, 2'b01, 0, 32'h202, 32'h12345678, 2, 1, 32'hFFFFFFFF, 0, 1);
    do_op(0, 2'b10, 0, 32'h102, 32'h0, 0, 0, 32'h0, 0, 0);
    do_op(0, 2'b01, 0, 32'h101, 32'h0, 0, 0, 32'h0, 0, 0);
    do_op(1, 2'b00, 0, 32'h103, 32'hA5A5A5C3, 0, 0, 32'h0, 0, 0);
    do_op(0, 2'b10, 0, 32'h104, 32'h0, 1, 2, 32'h0BADF00D, 1, 0);
    lsu_req = 0;
    @(negedge clk);
    chk("err_pulse", {31'd0, lsu_err}, 32'd0);
    step();

    // Timeout: never grant
    lsu_req = 1; lsu_we = 0; lsu_size = 2'b10; lsu_addr = 32'h400;
    cnt = 0; done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      @(negedge clk);
      if (!lsu_stall) done = 1;
      else if (bus_req) cnt++;
    end
    chk("tmo_done", {31'd0, done}, 32'd1);
    chk("tmo_req_cycles", cnt, TMO);
    chk("tmo_err", {31'd0, lsu_err}, 32'd1);
    chk("tmo_busreq", {31'd0, bus_req}, 32'd0);
    chk("tmo_rdata", lsu_rdata, m_rdata);
    step();
    lsu_req = 0; bus_rvalid = 1; bus_rdata = 32'h11112222; bus_err = 0;
    @(negedge clk);
    chk("tmo_err_once", {31'd0, lsu_err}, 32'd0);
    step();
    bus_rvalid = 0;
    @(negedge clk);
    chk("late_rv_err", {31'd0, lsu_err}, 32'd0);
    chk("late_rv_rdata", lsu_rdata, m_rdata);
    chk("late_rv_req", {31'd0, bus_req}, 32'd0);
    step();

    // Reset while waiting for a response
    lsu_req = 1; lsu_we = 0; lsu_size = 2'b10; lsu_addr = 32'h300;
    step();
    bus_gnt = 1;
    step();
    bus_gnt = 0;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busreq", {31'd0, bus_req}, 32'd0);
    chk("mid_rst_addr", bus_addr, 32'd0);
    chk("mid_rst_be", {28'd0, bus_be}, 32'd0);
    chk("mid_rst_rdata", lsu_rdata, 32'd0);
    m_rdata = '0;
    lsu_addr = 32'h302;
    #1;
    chk("mid_rst_idle", {31'd0, lsu_misalign}, 32'd1);
    lsu_req = 0;
    step(); step();
    reset = 1'b1;
    step();

    do_op(0, 2'b10, 0, 32'h500, 32'h0, 0, 0, 32'hCAFEF00D, 0, 0);
    do_op(0, 2'b10, 0, 32'h504, 32'h0, 0, 0, 32'h01020304, 0, 0);
    do_op(0, 2'b10, 0, 32'h508, 32'h0, 2, 0, 32'h55AA55AA, 0, 0);
    do_op(0, 2'b10, 0, 32'h50C, 32'h0, 5, 0, 32'h7F00FF01, 0, 0);

    for (int n = 0; n < 150; n++) begin
      do_op(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
            int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), $urandom,
            ($urandom_range(0, 7) == 0), 1'($urandom));
    end
    lsu_req = 0;
    @(negedge clk);
    chk("final_busreq", {31'd0, bus_req}, 32'd0);
    chk("final_rdata", lsu_rdata, m_rdata);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
